// File: rtl/usb_pkg.sv
// Shared USB serial-path definitions used by the transmit bit stuffer and
// the receive-side bit-stuff remover.
package usb_pkg;

   // Number of consecutive 1s after which a 0 is inserted on the wire.
   localparam int STUFF_LEN = 6;

   // Bit-stuffer FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      STUFF = 2'd2
   } bs_state_t;

endpackage

// File: rtl/bit_stuffer_encode_if.sv
// Serial bit stream between the packet serializer, the bit stuffer and the
// NRZI encoder.
//
// Handshake: a bit is transferred on a rising clock edge when in_sending=1
// and stall=0. While stall=1 the source holds in_bit and in_sending. On the
// output side each cycle with bs_sending=1 carries one bit on out_bit, and
// there is no backpressure.
interface bit_stuffer_encode_if;
   logic in_sending;
   logic in_bit;
   logic stall;
   logic out_bit;
   logic bs_sending;

   // Serializer side: drives bits and obeys stall.
   modport master (
      output in_sending,
      output in_bit,
      input  stall,
      input  out_bit,
      input  bs_sending
   );

   // Bit stuffer side.
   modport slave (
      input  in_sending,
      input  in_bit,
      output stall,
      output out_bit,
      output bs_sending
   );
endinterface

// File: rtl/bit_stuffer_encode_fsm.sv
// Bit-stuffer control: state register plus next-state and output decode.
// The counters themselves live in the top; this block only says when to
// bump or clear them.
module bit_stuffer_encode_fsm
   import usb_pkg::*;
(
   input  logic      clock,
   input  logic      reset_n,
   input  logic      in_sending,
   input  logic      in_bit,
   input  logic      run_full,   // ones_cnt == STUFF_LEN-1
   output logic      out_pass,   // out_bit follows in_bit this cycle
   output logic      bs_sending,
   output logic      stall,
   output logic      oc_inc,
   output logic      oc_clr,
   output logic      sc_inc,
   output logic      sc_clr,
   output bs_state_t state
);

   bs_state_t next_state;

   // State register; reset aborts any packet or pending stuffed bit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // Next-state and output decode. Outputs are gated by reset_n so they drop
   // the moment reset is asserted, even if upstream still presents a bit.
   // When oc_clr and oc_inc are both set the run counter loads 1.
   always_comb begin
      next_state = state;
      out_pass   = 1'b0;
      bs_sending = 1'b0;
      stall      = 1'b0;
      oc_inc     = 1'b0;
      oc_clr     = 1'b0;
      sc_inc     = 1'b0;
      sc_clr     = 1'b0;
      if (reset_n) begin
         unique case (state)
            IDLE: begin
               oc_clr = 1'b1;
               if (in_sending) begin
                  out_pass   = 1'b1;
                  bs_sending = 1'b1;
                  sc_clr     = 1'b1;
                  oc_inc     = in_bit;
                  next_state = SEND;
               end
            end
            SEND: begin
               if (in_sending) begin
                  out_pass   = 1'b1;
                  bs_sending = 1'b1;
                  if (!in_bit) begin
                     oc_clr = 1'b1;
                  end else if (run_full) begin
                     oc_clr     = 1'b1;
                     next_state = STUFF;
                  end else begin
                     oc_inc = 1'b1;
                  end
               end else begin
                  oc_clr     = 1'b1;
                  next_state = IDLE;
               end
            end
            STUFF: begin
               // Emit the inserted 0 and hold the upstream bit for one cycle.
               bs_sending = 1'b1;
               stall      = 1'b1;
               sc_inc     = 1'b1;
               next_state = in_sending ? SEND : IDLE;
            end
            default: next_state = IDLE;
         endcase
      end
   end

endmodule

// File: rtl/bit_stuffer_encode.sv
// Transmit USB bit stuffer: passes the serial stream through unchanged and
// inserts a 0 after every STUFF_LEN consecutive 1s, stalling the serializer
// for the inserted cycle. Also counts insertions per packet for status.
module bit_stuffer_encode
   import usb_pkg::*;
#(
   parameter int STUFF_LEN_P = usb_pkg::STUFF_LEN,
   parameter int CNT_W       = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   bit_stuffer_encode_if.slave  bus,
   output logic [CNT_W-1:0]     stuff_cnt,
   output bs_state_t            state
);

   localparam int OC_W = $clog2(STUFF_LEN_P + 1);

   logic [OC_W-1:0] ones_cnt;
   logic            run_full;
   logic            out_pass;
   logic            oc_inc;
   logic            oc_clr;
   logic            sc_inc;
   logic            sc_clr;

   assign run_full = (ones_cnt == OC_W'(STUFF_LEN_P - 1));

   bit_stuffer_encode_fsm u_fsm (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_sending (bus.in_sending),
      .in_bit     (bus.in_bit),
      .run_full   (run_full),
      .out_pass   (out_pass),
      .bs_sending (bus.bs_sending),
      .stall      (bus.stall),
      .oc_inc     (oc_inc),
      .oc_clr     (oc_clr),
      .sc_inc     (sc_inc),
      .sc_clr     (sc_clr),
      .state      (state)
   );

   // Inserted bits are 0, so the output mux reduces to a gate.
   assign bus.out_bit = out_pass & bus.in_bit;

   // Run length of 1s emitted since the last 0 (real or inserted).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)    ones_cnt <= '0;
      else if (oc_clr) ones_cnt <= OC_W'(oc_inc);
      else if (oc_inc) ones_cnt <= ones_cnt + 1'b1;
   end

   // Per-packet insertion count; holds after the packet, saturates at max.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         stuff_cnt <= '0;
      else if (sc_clr)
         stuff_cnt <= '0;
      else if (sc_inc && (stuff_cnt != {CNT_W{1'b1}}))
         stuff_cnt <= stuff_cnt + 1'b1;
   end

endmodule
